serial_fir_filter: RTL and testbench
====================================

// Module: serial_fir_filter
// PURPOSE
//  Bit-serial 3-tap (N_COEFF) FIR filter for narrow fixed-point streams.
//  Samples and coefficients arrive one bit per clock, LSB first, in a fixed frame.
//  Each frame yields one filtered sample, shifted out LSB first on o_data.
//  Used between serial sensor/ADC links and serial downstream processing.
// PARAMETERS
//  NB_DATA_IN   4  width of input sample and of each coefficient (signed Q1.(NB_DATA_IN-1))
//  NB_DATA_OUT  4  width of output sample (signed Q1.(NB_DATA_OUT-1)); must be <= 2*NB_DATA_IN-1
//  N_COEFF      3  number of taps
// PORTS
//  clk        in   1        system clock, rising edge
//  i_rst      in   1        asynchronous reset, active-low
//  i_en       in   1        global enable; low = all state holds
//  i_data     in   1        serial sample bit, LSB first
//  i_coeff    in   N_COEFF  serial coefficient bits; bit k = current bit of coeff k
//  o_data     out  1        serial filtered output bit, LSB first
// BEHAVIOUR
//  - Frame = 2*NB_DATA_IN cycles (N = NB_DATA_IN). Internal counter, width $clog2(2N), runs 0..2N-1, wraps.
//    It is named `counter`; the bench probes it hierarchically.
//  - Reset (i_rst=0, async): counter=0, all shift/delay/coeff/output regs=0, o_data=0.
//  - i_en=0: counter and every register hold. Rising-edge actions below occur only when i_en=1.
//  - Capture: at edges where counter ∈ {2N-1, 0, ..., N-2} (N edges), i_data and each i_coeff[k] shift into
//    their input shift registers (new bit enters MSB; shift right). After N edges, the word is LSB-aligned.
//  - Edge at counter==N-1: delay line x2<=x1, x1<=x0, x0<=data word; coeff regs c[k] <= coeff words.
//  - Edge at counter==N: compute S = sum_k c[k]*x[k] (signed, full precision; products 2N bits,
//    sum 2N+$clog2(N_COEFF) bits, 2(N-1) fraction bits). Output y = S >>> (2(N-1)-(NB_DATA_OUT-1))
//    (arithmetic, truncation toward -inf). Then reduce to NB_DATA_OUT bits per CONFIGURATION.
//    Load y into the output shift reg.
//  - All other edges: output shift reg shifts right with zero fill. o_data = out_sr[0] (registered).
//  - Hence y bit b is on o_data while counter == (N+1+b) mod 2N; b = 0..NB_DATA_OUT-1.
//    After that, o_data=0 until the next load.
//  - Latency: word whose last bit is captured at counter N-2 appears LSB-first starting 3 edges later.
//  - Inputs outside the capture window are ignored. Mid-frame reset aborts the frame; the next frame starts at counter 0.
//  - First frame after reset captures whatever is on i_data at counter 0..N-2. Feeders align to counter==2N-1.
// CONFIGURATION
//  - SERIAL_FIR_SAT_EN defined: y saturates to [-2^(NB_DATA_OUT-1), 2^(NB_DATA_OUT-1)-1].
//  - Not defined: y wraps (keep the low NB_DATA_OUT bits).
// STRUCTURE
//  - Package serial_fir_pkg: frame length and counter width, product/accumulator widths, output shift amount,
//    saturation limits, as functions of the parameters.
//  - One sub-module, serial_fir_sipo: NB-bit serial-in/parallel-out shift register with load-window enable.
//    Instantiated for the data path and for each coefficient lane.
//  - The MAC/sum is combinational in the top; there are no multicycle paths.
// TESTING (defaults N=4; coeffs 0111,1000,0111 = +7/8,-1,+7/8; all words LSB first)
//  1 Reset: i_rst=0 mid-frame -> o_data=0 and counter=0 immediately; all later outputs 0 with zero inputs.
//  2 Impulse-like: zeros, then 1001, 1001, 0110, 1010 -> outputs 1001, 0000, 0110, then last per macro.
//  3 Last case: S=-139/64 -> y=-18 -> with SERIAL_FIR_SAT_EN 1000, without 1110.
//  4 Enable gating: drop i_en for 5 cycles mid-capture -> counter/outputs freeze; resumed result unchanged.
//  5 Timing: o_data bit b while counter==(5+b) mod 8; o_data=0 at counter 1..4.
//  6 Random: 1024 random words, golden-model compare of every output word (both macro settings).

Source files
------------

// File: rtl/serial_fir_pkg.sv
// Shared sizing helpers for the bit-serial FIR filter: frame length, counter width,
// MAC widths, output alignment shift and saturation limits.
package serial_fir_pkg;

   localparam int DefNbDataIn  = 4;
   localparam int DefNbDataOut = 4;
   localparam int DefNCoeff    = 3;

   function automatic int frameLen(input int nbIn);
      return 2 * nbIn;
   endfunction

   function automatic int cntWidth(input int nbIn);
      return $clog2(2 * nbIn);
   endfunction

   function automatic int prodWidth(input int nbIn);
      return 2 * nbIn;
   endfunction

   function automatic int accWidth(input int nbIn, input int nCoeff);
      return 2 * nbIn + $clog2(nCoeff);
   endfunction

   // Products carry 2(N-1) fraction bits; drop the ones the output format cannot hold.
   function automatic int outShift(input int nbIn, input int nbOut);
      return 2 * (nbIn - 1) - (nbOut - 1);
   endfunction

   function automatic int satMax(input int nbOut);
      return (2 ** (nbOut - 1)) - 1;
   endfunction

   function automatic int satMin(input int nbOut);
      return -(2 ** (nbOut - 1));
   endfunction

endpackage

// File: rtl/serial_fir_sipo.sv
// Serial-in/parallel-out shift register: new bit enters the MSB while shiftEn_i is high,
// so after NB shifts of an LSB-first stream the word sits LSB-aligned.
module serial_fir_sipo #(
   parameter int NB = 4
) (
   input  logic          clk_i,
   input  logic          rstN_i,
   input  logic          shiftEn_i,
   input  logic          serial_i,
   output logic [NB-1:0] word_o
);

   logic [NB-1:0] shiftReg_q;
   logic [NB-1:0] shiftReg_d;

   always_comb begin
      shiftReg_d = shiftReg_q;
      if (shiftEn_i) begin
         shiftReg_d = {serial_i, shiftReg_q[NB-1:1]};
      end
   end

   always_ff @(posedge clk_i or negedge rstN_i) begin
      if (!rstN_i) begin
         shiftReg_q <= '0;
      end else begin
         shiftReg_q <= shiftReg_d;
      end
   end

   assign word_o = shiftReg_q;

endmodule

// File: rtl/serial_fir_filter.sv
// Bit-serial N_COEFF-tap FIR filter, one output word per 2*NB_DATA_IN-cycle frame.
// Define SERIAL_FIR_SAT_EN to saturate the output word; otherwise it wraps.
module serial_fir_filter
   import serial_fir_pkg::*;
#(
   parameter int NB_DATA_IN  = DefNbDataIn,
   parameter int NB_DATA_OUT = DefNbDataOut,
   parameter int N_COEFF     = DefNCoeff
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               i_en,
   input  logic               i_data,
   input  logic [N_COEFF-1:0] i_coeff,
   output logic               o_data
);

   localparam int FrameLen = frameLen(NB_DATA_IN);
   localparam int CntW     = cntWidth(NB_DATA_IN);
   localparam int ProdW    = prodWidth(NB_DATA_IN);
   localparam int AccW     = accWidth(NB_DATA_IN, N_COEFF);
   localparam int OutShift = outShift(NB_DATA_IN, NB_DATA_OUT);

   localparam logic [CntW-1:0] LastCnt    = CntW'(FrameLen - 1);
   localparam logic [CntW-1:0] CaptureEnd = CntW'(NB_DATA_IN - 2);
   localparam logic [CntW-1:0] LoadCnt    = CntW'(NB_DATA_IN - 1);
   localparam logic [CntW-1:0] CalcCnt    = CntW'(NB_DATA_IN);

   logic [CntW-1:0] counter;
   logic [CntW-1:0] counter_d;
   logic            captureEn;

   logic [NB_DATA_IN-1:0]        dataWord;
   logic [NB_DATA_IN-1:0]        coeffWord [N_COEFF];
   logic signed [NB_DATA_IN-1:0] x_q [N_COEFF];
   logic signed [NB_DATA_IN-1:0] x_d [N_COEFF];
   logic signed [NB_DATA_IN-1:0] c_q [N_COEFF];
   logic signed [NB_DATA_IN-1:0] c_d [N_COEFF];

   logic signed [ProdW-1:0] prod [N_COEFF];
   logic signed [AccW-1:0]  acc;
   logic [NB_DATA_OUT-1:0]  y;
   logic [NB_DATA_OUT-1:0]  outSr_q;
   logic [NB_DATA_OUT-1:0]  outSr_d;

   // Capture window straddles the frame boundary: counter 2N-1 then 0..N-2.
   assign captureEn = i_en && ((counter == LastCnt) || (counter <= CaptureEnd));
   assign counter_d = (counter == LastCnt) ? '0 : counter + 1'b1;

   serial_fir_sipo #(.NB(NB_DATA_IN)) u_dataSipo (
      .clk_i     (clk),
      .rstN_i    (i_rst),
      .shiftEn_i (captureEn),
      .serial_i  (i_data),
      .word_o    (dataWord)
   );

   for (genvar k = 0; k < N_COEFF; k++) begin : g_coeffLane
      serial_fir_sipo #(.NB(NB_DATA_IN)) u_coeffSipo (
         .clk_i     (clk),
         .rstN_i    (i_rst),
         .shiftEn_i (captureEn),
         .serial_i  (i_coeff[k]),
         .word_o    (coeffWord[k])
      );
   end

   always_comb begin
      x_d = x_q;
      c_d = c_q;
      if (i_en && (counter == LoadCnt)) begin
         x_d[0] = dataWord;
         for (int k = 1; k < N_COEFF; k++) begin
            x_d[k] = x_q[k-1];
         end
         for (int k = 0; k < N_COEFF; k++) begin
            c_d[k] = coeffWord[k];
         end
      end
   end

   always_comb begin
      acc = '0;
      for (int k = 0; k < N_COEFF; k++) begin
         prod[k] = ProdW'(x_q[k]) * ProdW'(c_q[k]);
         acc     = acc + AccW'(prod[k]);
      end
   end

`ifdef SERIAL_FIR_SAT_EN
   localparam logic signed [AccW-1:0] SatMaxW = AccW'(satMax(NB_DATA_OUT));
   localparam logic signed [AccW-1:0] SatMinW = AccW'(satMin(NB_DATA_OUT));
   localparam logic [NB_DATA_OUT-1:0] YMax    = NB_DATA_OUT'(satMax(NB_DATA_OUT));
   localparam logic [NB_DATA_OUT-1:0] YMin    = NB_DATA_OUT'(satMin(NB_DATA_OUT));

   logic signed [AccW-1:0] shifted;
   assign shifted = acc >>> OutShift;

   always_comb begin
      y = shifted[NB_DATA_OUT-1:0];
      if (shifted > SatMaxW) begin
         y = YMax;
      end else if (shifted < SatMinW) begin
         y = YMin;
      end
   end
`else
   assign y = NB_DATA_OUT'(acc >>> OutShift);
`endif

   // The result is loaded once per frame; every other enabled edge drains it LSB first.
   always_comb begin
      outSr_d = outSr_q;
      if (i_en) begin
         if (counter == CalcCnt) begin
            outSr_d = y;
         end else begin
            outSr_d = {1'b0, outSr_q[NB_DATA_OUT-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         counter <= '0;
         x_q     <= '{default: '0};
         c_q     <= '{default: '0};
         outSr_q <= '0;
      end else begin
         if (i_en) begin
            counter <= counter_d;
         end
         x_q     <= x_d;
         c_q     <= c_d;
         outSr_q <= outSr_d;
      end
   end

   assign o_data = outSr_q[0];

endmodule

// File: tb/tb_serial_fir_filter.sv
// Directed and random checks for serial_fir_filter (N=4 defaults); expected words follow
// SERIAL_FIR_SAT_EN the same way the design does.
module tb_serial_fir_filter;

   typedef struct {
      logic [3:0] data;
      logic [3:0] c0;
      logic [3:0] c1;
      logic [3:0] c2;
      logic [3:0] expY;
   } vec_t;

   localparam logic [3:0] C0 = 4'b0111;
   localparam logic [3:0] C1 = 4'b1000;
   localparam logic [3:0] C2 = 4'b0111;
`ifdef SERIAL_FIR_SAT_EN
   localparam logic [3:0] Y4 = 4'b1000;
   localparam logic [3:0] Y5 = 4'b0111;
   localparam logic [3:0] Y6 = 4'b1000;
`else
   localparam logic [3:0] Y4 = 4'b1110;
   localparam logic [3:0] Y5 = 4'b0001;
   localparam logic [3:0] Y6 = 4'b0011;
`endif

   logic       clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_en = 1'b1;
   logic       i_data = 1'b0;
   logic [2:0] i_coeff = 3'b000;
   logic       o_data;

   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];

   serial_fir_filter #(.NB_DATA_IN(4), .NB_DATA_OUT(4), .N_COEFF(3)) dut (
      .clk     (clk),
      .i_rst   (i_rst),
      .i_en    (i_en),
      .i_data  (i_data),
      .i_coeff (i_coeff),
      .o_data  (o_data)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int sv(input logic [3:0] w);
      return int'($signed(w));
   endfunction

   // Golden model: full-precision sum, floor shift by 3, then saturate or wrap to 4 bits.
   function automatic logic [3:0] refY(input int x0, input int x1, input int x2,
                                       input int c0, input int c1, input int c2);
      int s;
      int y;
      s = c0 * x0 + c1 * x1 + c2 * x2;
      y = s >>> 3;
`ifdef SERIAL_FIR_SAT_EN
      if (y > 7) y = 7;
      if (y < -8) y = -8;
`endif
      return 4'(y);
   endfunction

   task automatic applyReset();
      i_en    = 1'b1;
      i_data  = 1'b0;
      i_coeff = '0;
      #2 i_rst = 1'b0;
      #1;
      checkOutput("reset counter", int'(dut.counter), 0);
      checkOutput("reset odata", int'(o_data), 0);
      @(negedge clk);
      i_rst = 1'b1;
   endtask

   task automatic startClean();
      applyReset();
      repeat (7) tick();
      checkOutput("aligned counter", int'(dut.counter), 7);
   endtask

   function automatic int expOdata(input int i, input int j);
      if (j >= 6 && i < vecs.size()) return int'(vecs[i].expY[j-6]);
      if (j <= 1 && i > 0) return int'(vecs[i-1].expY[j+2]);
      return 0;
   endfunction

   task automatic holdEnable(input int n, input int expCnt, input int expOd);
      logic       dSave;
      logic [2:0] cSave;
      dSave = i_data;
      cSave = i_coeff;
      i_en  = 1'b0;
      repeat (n) begin
         i_data  = 1'($urandom_range(0, 1));
         i_coeff = 3'($urandom_range(0, 7));
         tick();
         checkOutput("hold counter", int'(dut.counter), expCnt);
         checkOutput("hold odata", int'(o_data), expOd);
      end
      i_data  = dSave;
      i_coeff = cSave;
      i_en    = 1'b1;
   endtask

   // Streams every vector starting at counter 7, plus one zero window to flush the last word.
   task automatic applyStimulus(input string tag, input int gw0, input int gs0,
                                input int gw1, input int gs1);
      int n;
      logic [3:0] outWord;
      n = vecs.size();
      outWord = '0;
      for (int i = 0; i <= n; i++) begin
         for (int j = 0; j < 8; j++) begin
            if (j < 4) begin
               if (i < n) begin
                  i_data  = vecs[i].data[j];
                  i_coeff = {vecs[i].c2[j], vecs[i].c1[j], vecs[i].c0[j]};
               end else begin
                  i_data  = 1'b0;
                  i_coeff = '0;
               end
            end else begin
               i_data  = 1'($urandom_range(0, 1));
               i_coeff = 3'($urandom_range(0, 7));
            end
            if ((i == gw0 && j == gs0) || (i == gw1 && j == gs1)) begin
               holdEnable(5, (j + 7) % 8, expOdata(i, j));
            end
            tick();
            checkOutput({tag, " counter"}, int'(dut.counter), j);
            if (j == 0 && i > 0) begin
               outWord[3] = o_data;
               checkOutput($sformatf("%s word %0d", tag, i - 1), int'(outWord), int'(vecs[i-1].expY));
            end else if (j >= 1 && j <= 4) begin
               checkOutput({tag, " idle"}, int'(o_data), 0);
            end else if (j >= 5) begin
               outWord[j-5] = o_data;
            end
         end
      end
   endtask

   task automatic pushVec(input logic [3:0] d, input logic [3:0] y);
      vec_t v;
      v.data = d;
      v.c0   = C0;
      v.c1   = C1;
      v.c2   = C2;
      v.expY = y;
      vecs.push_back(v);
   endtask

   task automatic fillImpulse();
      vecs.delete();
      pushVec(4'b0000, 4'b0000);
      pushVec(4'b1001, 4'b1001);
      pushVec(4'b1001, 4'b0000);
      pushVec(4'b0110, 4'b0110);
      pushVec(4'b1010, Y4);
      pushVec(4'b0111, Y5);
      pushVec(4'b0000, Y6);
      pushVec(4'b0000, 4'b0110);
      pushVec(4'b0000, 4'b0000);
   endtask

   task automatic fillRandom(input int n);
      vec_t v;
      int   x1;
      int   x2;
      vecs.delete();
      x1 = 0;
      x2 = 0;
      for (int i = 0; i < n; i++) begin
         v.data = 4'($urandom_range(0, 15));
         v.c0   = 4'($urandom_range(0, 15));
         v.c1   = 4'($urandom_range(0, 15));
         v.c2   = 4'($urandom_range(0, 15));
         v.expY = refY(sv(v.data), x1, x2, sv(v.c0), sv(v.c1), sv(v.c2));
         vecs.push_back(v);
         x2 = x1;
         x1 = sv(v.data);
      end
   endtask

   initial begin
      logic [3:0] w;
      w = 4'b1001;

      // Mid-frame reset while a 1 is on o_data, then zero inputs must give zero outputs.
      startClean();
      for (int j = 0; j < 6; j++) begin
         if (j < 4) begin
            i_data  = w[j];
            i_coeff = {C2[j], C1[j], C0[j]};
         end else begin
            i_data  = 1'b0;
            i_coeff = '0;
         end
         tick();
      end
      checkOutput("pre-reset odata", int'(o_data), 1);
      checkOutput("pre-reset counter", int'(dut.counter), 5);
      i_data  = 1'b0;
      i_coeff = '0;
      #2 i_rst = 1'b0;
      #1;
      checkOutput("async reset odata", int'(o_data), 0);
      checkOutput("async reset counter", int'(dut.counter), 0);
      @(negedge clk);
      i_rst = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         tick();
         checkOutput("post-reset counter", int'(dut.counter), k % 8);
         checkOutput("post-reset odata", int'(o_data), 0);
      end

      startClean();
      fillImpulse();
      applyStimulus("impulse", -1, -1, -1, -1);

      startClean();
      fillImpulse();
      applyStimulus("gated", 1, 6, 2, 2);

      startClean();
      fillRandom(1024);
      applyStimulus("random", -1, -1, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
